bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_pkg.sv | 13 +
 rtl/bram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package bram_pkg;

  localparam int unsigned BURST_CNT_W = 8;
  localparam int unsigned STAT_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_WR = 2'd1,
    OWN_RD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bram_port_arbiter.sv
// Two-requester (writer/reader) arbiter for a single BRAM port.
// Bursts are capped at MAX_BURST only while the other side is waiting.
// Optional macro BRAM_ARB_STATS_EN adds write/read/forced-switch counters.
module bram_port_arbiter
  import bram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 13,
  parameter int unsigned BRAM_DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_req_i,
  input  logic [ADDRESS_WIDTH-1:0]   wr_addr_i,
  input  logic [BRAM_DATA_WIDTH-1:0] wr_data_i,
  output logic                       wr_gnt_o,
  input  logic                       rd_req_i,
  input  logic [ADDRESS_WIDTH-1:0]   rd_addr_i,
  output logic                       rd_gnt_o,
  output logic [BRAM_DATA_WIDTH-1:0] rd_data_o,
  output logic                       rd_valid_o,
  output logic [ADDRESS_WIDTH-1:0]   bram_addr,
  output logic                       bram_en,
  output logic                       bram_we,
  output logic [BRAM_DATA_WIDTH-1:0] bram_data_in,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_data_out
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0]      stat_wr_cnt_o,
  output logic [STAT_CNT_W-1:0]      stat_rd_cnt_o,
  output logic [STAT_CNT_W-1:0]      stat_force_cnt_o
`endif
);

  // Last access of a burst when the other side is waiting.
  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);
  localparam logic [BURST_CNT_W-1:0] CNT_MAX    = '1;

  arb_state_t               state_q, state_d;
  // Set once the reader has been granted; the writer then wins the next tie.
  logic                     last_wr_q, last_wr_d;
  logic [BURST_CNT_W-1:0]   burst_cnt, burst_cnt_d;
  logic                     wr_gnt_q, rd_gnt_q, rd_valid_q;
  logic                     wr_acc, rd_acc;

  assign wr_acc = (state_q == OWN_WR) && wr_req_i;
  assign rd_acc = (state_q == OWN_RD) && rd_req_i;

  // Next-state, tie-break flag and burst counter.
  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    burst_cnt_d = burst_cnt;
    unique case (state_q)
      IDLE: begin
        if (wr_req_i && rd_req_i) state_d = last_wr_q ? OWN_WR : OWN_RD;
        else if (wr_req_i)        state_d = OWN_WR;
        else if (rd_req_i)        state_d = OWN_RD;
      end
      OWN_WR: begin
        if (!wr_req_i)                                  state_d = rd_req_i ? OWN_RD : IDLE;
        else if (rd_req_i && (burst_cnt >= BURST_LAST)) state_d = OWN_RD;
      end
      OWN_RD: begin
        if (!rd_req_i)                                  state_d = wr_req_i ? OWN_WR : IDLE;
        else if (wr_req_i && (burst_cnt >= BURST_LAST)) state_d = OWN_WR;
      end
      default: state_d = IDLE;
    endcase
    if ((state_d == OWN_WR) && (state_q != OWN_WR)) last_wr_d = 1'b0;
    if ((state_d == OWN_RD) && (state_q != OWN_RD)) last_wr_d = 1'b1;
    if (state_d != state_q)
      burst_cnt_d = '0;
    else if ((wr_acc || rd_acc) && (burst_cnt != CNT_MAX))
      burst_cnt_d = burst_cnt + BURST_CNT_W'(1);
  end

  // State, grants, read-valid pipeline.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_wr_q  <= 1'b0;
      burst_cnt  <= '0;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      burst_cnt  <= burst_cnt_d;
      wr_gnt_q   <= (state_d == OWN_WR);
      rd_gnt_q   <= (state_d == OWN_RD);
      rd_valid_q <= rd_acc;
    end
  end

  // BRAM port drive follows the current owner's request.
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    if (wr_acc) begin
      bram_en   = 1'b1;
      bram_we   = 1'b1;
      bram_addr = wr_addr_i;
    end else if (rd_acc) begin
      bram_en   = 1'b1;
      bram_addr = rd_addr_i;
    end
  end

  assign bram_data_in = wr_data_i;
  assign rd_data_o    = bram_data_out;
  assign wr_gnt_o     = wr_gnt_q;
  assign rd_gnt_o     = rd_gnt_q;
  assign rd_valid_o   = rd_valid_q;

`ifdef BRAM_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;

  if (STATS_EN) begin : g_stats
    logic [STAT_CNT_W-1:0] wr_cnt_q, rd_cnt_q, force_cnt_q;
    logic                  force_evt;

    // Ownership leaves while the owner still requests: a burst-cap switch.
    assign force_evt = (wr_acc && (state_d == OWN_RD)) || (rd_acc && (state_d == OWN_WR));

    // Free-running wrapping event counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_cnt_q    <= '0;
        rd_cnt_q    <= '0;
        force_cnt_q <= '0;
      end else begin
        if (wr_acc)    wr_cnt_q    <= wr_cnt_q + STAT_CNT_W'(1);
        if (rd_acc)    rd_cnt_q    <= rd_cnt_q + STAT_CNT_W'(1);
        if (force_evt) force_cnt_q <= force_cnt_q + STAT_CNT_W'(1);
      end
    end

    assign stat_wr_cnt_o    = wr_cnt_q;
    assign stat_rd_cnt_o    = rd_cnt_q;
    assign stat_force_cnt_o = force_cnt_q;
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a behavioural BRAM and a
// read-data scoreboard. Stats checks compile in with BRAM_ARB_STATS_EN.
module tb_bram_port_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_req_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0;
  logic          wr_gnt_o;
  logic          rd_req_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          rd_gnt_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          bram_we;
  logic [DW-1:0] bram_data_in;
  logic [DW-1:0] bram_data_out = '0;
`ifdef BRAM_ARB_STATS_EN
  logic [31:0]   stat_wr_cnt_o, stat_rd_cnt_o, stat_force_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int wr_acc_cnt = 0;
  int rd_acc_cnt = 0;

  logic [DW-1:0] mem      [DEPTH];
  bit            mem_wr   [DEPTH];
  logic [DW-1:0] exp_mem  [DEPTH];
  bit            exp_wr   [DEPTH];
  logic [DW-1:0] rd_exp_q [$];
  logic [DW-1:0] exp_d;

  bram_port_arbiter #(
    .ADDRESS_WIDTH  (AW),
    .BRAM_DATA_WIDTH(DW),
    .MAX_BURST      (MB)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .wr_req_i        (wr_req_i),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .wr_gnt_o        (wr_gnt_o),
    .rd_req_i        (rd_req_i),
    .rd_addr_i       (rd_addr_i),
    .rd_gnt_o        (rd_gnt_o),
    .rd_data_o       (rd_data_o),
    .rd_valid_o      (rd_valid_o),
    .bram_addr       (bram_addr),
    .bram_en         (bram_en),
    .bram_we         (bram_we),
    .bram_data_in    (bram_data_in),
    .bram_data_out   (bram_data_out)
`ifdef BRAM_ARB_STATS_EN
    ,
    .stat_wr_cnt_o   (stat_wr_cnt_o),
    .stat_rd_cnt_o   (stat_rd_cnt_o),
    .stat_force_cnt_o(stat_force_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst_i    = 1'b1;
    wr_req_i = 1'b0;
    rd_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Behavioural BRAM, one-cycle read latency.
  always @(posedge clk_i) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr]    <= bram_data_in;
        mem_wr[bram_addr] <= 1'b1;
      end else begin
        bram_data_out <= mem_wr[bram_addr] ? mem[bram_addr] : init_word(bram_addr);
      end
    end
  end

  // Port monitor and read scoreboard.
  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_rd_valid", 32'(rd_valid_o), 0);
      chk("rst_wr_gnt", 32'(wr_gnt_o), 0);
      chk("rst_rd_gnt", 32'(rd_gnt_o), 0);
      chk("rst_bram_en", 32'(bram_en), 0);
      rd_exp_q.delete();
    end else begin
      if (rd_exp_q.size() != 0) begin
        exp_d = rd_exp_q.pop_front();
        chk("rd_valid", 32'(rd_valid_o), 1);
        chk("rd_data", rd_data_o, exp_d);
      end else begin
        chk("rd_valid_idle", 32'(rd_valid_o), 0);
      end
      chk("gnt_excl", 32'(wr_gnt_o & rd_gnt_o), 0);
      chk("bram_din", bram_data_in, wr_data_i);
      if (wr_gnt_o && wr_req_i) begin
        chk("wr_en", 32'(bram_en), 1);
        chk("wr_we", 32'(bram_we), 1);
        chk("wr_addr", 32'(bram_addr), 32'(wr_addr_i));
        exp_mem[wr_addr_i] = wr_data_i;
        exp_wr[wr_addr_i]  = 1'b1;
        wr_acc_cnt++;
      end else if (rd_gnt_o && rd_req_i) begin
        chk("rd_en", 32'(bram_en), 1);
        chk("rd_we", 32'(bram_we), 0);
        chk("rd_addr", 32'(bram_addr), 32'(rd_addr_i));
        rd_exp_q.push_back(exp_wr[rd_addr_i] ? exp_mem[rd_addr_i] : init_word(rd_addr_i));
        rd_acc_cnt++;
      end else begin
        chk("idle_en", 32'(bram_en), 0);
        chk("idle_we", 32'(bram_we), 0);
        chk("idle_addr", 32'(bram_addr), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bit took, rtook;
    logic [AW-1:0] rd_ofs;

    // Reader alone, addresses 5..8.
    do_reset();
    rd_acc_cnt = 0;
    rd_req_i = 1'b1; rd_addr_i = AW'(5);
    @(negedge clk_i); chk("t1_c0_rd_gnt", 32'(rd_gnt_o), 0);
    for (int i = 0; i < 4; i++) begin
      step(); rd_addr_i = AW'(5 + i);
      @(negedge clk_i); chk("t1_rd_gnt", 32'(rd_gnt_o), 1);
    end
    step(); rd_req_i = 1'b0;
    @(negedge clk_i); chk("t1_c5_gnt_hold", 32'(rd_gnt_o), 1);
    step();
    @(negedge clk_i); chk("t1_c6_idle", 32'(rd_gnt_o), 0);
    chk("t1_rd_count", 32'(rd_acc_cnt), 4);

    // Simultaneous requests out of reset, reader first then writer with no gap.
    do_reset();
    wr_req_i = 1'b1; wr_addr_i = AW'(32); wr_data_i = 32'hDEAD_0001;
    rd_req_i = 1'b1; rd_addr_i = AW'(32);
    @(negedge clk_i); chk("t2_c0_gnts", {30'd0, wr_gnt_o, rd_gnt_o}, 0);
    step();
    @(negedge clk_i); chk("t2_c1_rd_gnt", 32'(rd_gnt_o), 1); chk("t2_c1_wr_gnt", 32'(wr_gnt_o), 0);
    step(); rd_addr_i = AW'(33);
    @(negedge clk_i); chk("t2_c2_rd_gnt", 32'(rd_gnt_o), 1);
    step(); rd_req_i = 1'b0;
    @(negedge clk_i); chk("t2_c3_wr_gnt", 32'(wr_gnt_o), 0);
    step();
    @(negedge clk_i); chk("t2_c4_wr_gnt", 32'(wr_gnt_o), 1); chk("t2_c4_rd_gnt", 32'(rd_gnt_o), 0);
    step(); wr_addr_i = AW'(33); wr_data_i = 32'hDEAD_0002;
    @(negedge clk_i); chk("t2_c5_wr_gnt", 32'(wr_gnt_o), 1);
    step(); wr_req_i = 1'b0;
    step();
    @(negedge clk_i); chk("t2_c7_idle", {30'd0, wr_gnt_o, rd_gnt_o}, 0);
    // Read back the two written words.
    rd_req_i = 1'b1; rd_addr_i = AW'(32);
    step();
    step(); rd_addr_i = AW'(33);
    step(); rd_req_i = 1'b0;
    step(); step();

    // Tie after the reader was served goes to the writer.
    do_reset();
    rd_req_i = 1'b1; rd_addr_i = AW'(3);
    step();
    step(); rd_req_i = 1'b0;
    step();
    wr_req_i = 1'b1; wr_addr_i = AW'(64); wr_data_i = 32'h1234_5678;
    rd_req_i = 1'b1; rd_addr_i = AW'(64);
    @(negedge clk_i); chk("t3_tie_idle", {30'd0, wr_gnt_o, rd_gnt_o}, 0);
    step();
    @(negedge clk_i); chk("t3_tie_wr", 32'(wr_gnt_o), 1);
    wr_req_i = 1'b0;
    step();
    @(negedge clk_i); chk("t3_then_rd", 32'(rd_gnt_o), 1);
    step(); rd_req_i = 1'b0;
    step(); step();

    // Burst cap: writer 10 cycles, reader from cycle 2.
    do_reset();
    wr_acc_cnt = 0; rd_acc_cnt = 0;
    took = 1'b0; rtook = 1'b0; rd_ofs = '0;
    wr_addr_i = AW'(128); wr_data_i = 32'hC0DE_0000;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      if (took) begin wr_addr_i = wr_addr_i + AW'(1); wr_data_i = wr_data_i + 32'd1; end
      if (rtook) rd_ofs = rd_ofs + AW'(1);
      wr_req_i  = (c < 10);
      rd_req_i  = (c >= 2) && (c < 8);
      rd_addr_i = AW'(128) + rd_ofs;
      @(negedge clk_i);
      took  = wr_gnt_o && wr_req_i;
      rtook = rd_gnt_o && rd_req_i;
      if (c == 4) chk("t4_c4_wr_gnt", 32'(wr_gnt_o), 1);
      if (c == 5) begin
        chk("t4_c5_rd_gnt", 32'(rd_gnt_o), 1);
        chk("t4_c5_writes", 32'(wr_acc_cnt), MB);
      end
      if (c == 8) chk("t4_c8_rd_gnt", 32'(rd_gnt_o), 1);
      if (c == 9) chk("t4_c9_wr_back", 32'(wr_gnt_o), 1);
      if (c == 11) chk("t4_c11_idle", {30'd0, wr_gnt_o, rd_gnt_o}, 0);
    end
    chk("t4_wr_total", 32'(wr_acc_cnt), 5);
    chk("t4_rd_total", 32'(rd_acc_cnt), 3);
`ifdef BRAM_ARB_STATS_EN
    chk("t4_stat_force", stat_force_cnt_o, 1);
    chk("t4_stat_wr", stat_wr_cnt_o, 5);
    chk("t4_stat_rd", stat_rd_cnt_o, 3);
`endif

    // Writer alone for 300 cycles: grant held, counter saturates.
    do_reset();
    wr_req_i = 1'b1; wr_addr_i = AW'(256); wr_data_i = 32'h5000_0000;
    for (int c = 0; c <= 300; c++) begin
      if (c > 0) begin
        step();
        wr_addr_i = wr_addr_i + AW'(1);
        wr_data_i = wr_data_i + 32'd1;
      end
      @(negedge clk_i);
      if (c > 0) chk("t5_wr_held", 32'(wr_gnt_o), 1);
    end
    chk("t5_burst_sat", 32'(dut.burst_cnt), 255);
`ifdef BRAM_ARB_STATS_EN
    chk("t5_no_force", stat_force_cnt_o, 0);
`endif
    step(); rd_req_i = 1'b1; rd_addr_i = AW'(7);
    @(negedge clk_i); chk("t5_c301_wr", 32'(wr_gnt_o), 1);
    step();
    @(negedge clk_i); chk("t5_c302_rd", 32'(rd_gnt_o), 1);
`ifdef BRAM_ARB_STATS_EN
    chk("t5_force_one", stat_force_cnt_o, 1);
`endif
    wr_req_i = 1'b0;
    step(); rd_req_i = 1'b0;
    step(); step();

    // Reset right after a read access drops the pending valid.
    do_reset();
    rd_req_i = 1'b1; rd_addr_i = AW'(9);
    step();
    @(negedge clk_i); chk("t6_c1_rd_gnt", 32'(rd_gnt_o), 1);
    step();
    rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(rd_valid_o), 0);
    chk("t6_rst_gnts", {30'd0, wr_gnt_o, rd_gnt_o}, 0);
    chk("t6_rst_en", 32'(bram_en), 0);
    chk("t6_rst_cnt", 32'(dut.burst_cnt), 0);
    rd_req_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    wr_req_i = 1'b1; wr_addr_i = AW'(512); wr_data_i = 32'h7777_0000;
    rd_req_i = 1'b1; rd_addr_i = AW'(9);
    @(negedge clk_i); chk("t6_post_idle", {30'd0, wr_gnt_o, rd_gnt_o}, 0);
    step();
    @(negedge clk_i); chk("t6_post_rd_prio", 32'(rd_gnt_o), 1);
    rd_req_i = 1'b0;
    step();
    @(negedge clk_i); chk("t6_post_wr", 32'(wr_gnt_o), 1);
    wr_req_i = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
